ensemble_vote_scheduler: RTL and testbench
==========================================

// Module: ensemble_vote_scheduler
// PURPOSE
//  Front/back-end controller for the three-classifier ensemble (gradient boost, Gaussian NB, SVM).
//  Forks one host AXI-Stream feature vector to all three classifier input streams.
//  Collects exactly one result beat per classifier and majority-votes the class label.
//  Emits one voted result beat. Sits between the host DMA streams and the ensemble wrapper.
// PARAMETERS
//  DATA_WIDTH      32    tdata width of every stream.
//  KEEP_WIDTH      4     tkeep width (DATA_WIDTH/8).
//  LABEL_W         8     label field = result tdata[LABEL_W-1:0].
//  TIE_PRIO        0     classifier index whose label wins a 3-way disagreement (0..2).
//  TIMEOUT_CYCLES  4096  collect watchdog limit (only used with ENSEMBLE_TIMEOUT_EN).
// PORTS
//  clk             in   1             clock.
//  rst             in   1             synchronous, active-high reset.
//  s_axis_tdata    in   DATA_WIDTH    host feature beat.
//  s_axis_tkeep    in   KEEP_WIDTH    host byte enables.
//  s_axis_tvalid   in   1             host valid.
//  s_axis_tready   out  1             host ready.
//  s_axis_tlast    in   1             last feature of the vector.
//  cls_s_tdata     out  DATA_WIDTH    broadcast feature beat (shared by all 3).
//  cls_s_tkeep     out  KEEP_WIDTH    broadcast tkeep.
//  cls_s_tlast     out  1             broadcast tlast.
//  cls_s_tvalid    out  3             per-classifier valid.
//  cls_s_tready    in   3             per-classifier ready.
//  cls_r_tdata     in   3*DATA_WIDTH  results; classifier i at [i*DATA_WIDTH +: DATA_WIDTH].
//  cls_r_tvalid    in   3             per-classifier result valid.
//  cls_r_tready    out  3             per-classifier result ready.
//  m_axis_tdata    out  DATA_WIDTH    voted result (field layout below).
//  m_axis_tkeep    out  KEEP_WIDTH    all ones when valid.
//  m_axis_tvalid   out  1             result valid.
//  m_axis_tready   in   1             host ready.
//  m_axis_tlast    out  1             always 1 with tvalid.
//  busy            out  1             high whenever the FSM is not in IDLE.
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM to IDLE; captured-result mask, fork mask and counters cleared.
//   - A reset mid-vector abandons the vector; classifier beats already in flight are not drained.
//  FSM: IDLE -> FORK -> COLLECT -> OUT -> IDLE.
//   - IDLE: s_axis_tready=1. An accepted beat is registered into the fork buffer; go to FORK.
//   - FORK: cls_s_tvalid[i]=1 for every branch not yet accepted (done mask).
//     - A branch handshake sets its done bit.
//     - When all 3 bits are set, the beat retires and the mask clears.
//     - s_axis_tready=1 only in the retiring cycle. This allows back-to-back beats with no bubble
//       when all three branches are ready.
//     - Retiring a beat with tlast=1 moves the FSM to COLLECT.
//   - COLLECT: cls_r_tready[i]=1 while result i is not yet captured.
//     - Capture the label and set got[i]; ignore the result's tlast.
//     - When got==3'b111, vote and go to OUT. Outside COLLECT, cls_r_tready=0.
//   - OUT: m_axis_tvalid held stable until m_axis_tready; then go to IDLE.
//  Vote:
//   - Majority if at least 2 captured labels are equal; agree = matching count.
//   - If all 3 differ, the label comes from TIE_PRIO and agree=1.
//  m_axis_tdata layout:
//   - [LABEL_W-1:0]           label.
//   - [LABEL_W+1:LABEL_W]     agree.
//   - [LABEL_W+4:LABEL_W+2]   got mask.
//   - [LABEL_W+5]             timeout flag.
//   - remaining bits 0.
//  Latency: last result capture -> m_axis_tvalid is 1 cycle (vote registered).
//  Simultaneous results in one cycle are all captured. A single-beat vector (tlast on beat 0) is legal.
// CONFIGURATION
//  ENSEMBLE_TIMEOUT_EN defined:
//   - A cycle counter runs in COLLECT and clears on entry.
//   - At TIMEOUT_CYCLES, vote over captured results only.
//   - Voting with 2 captured labels that differ takes the lower-index label.
//   - With 0 captured: label=0, agree=0.
//   - Sets the timeout flag and moves to OUT; uncaptured branches get cls_r_tready=0 from then on.
//  ENSEMBLE_TIMEOUT_EN undefined: no counter; COLLECT waits indefinitely; timeout flag is tied 0.
// STRUCTURE
//  Package ensemble_pkg:
//   - NUM_CLS=3.
//   - FSM state enum (IDLE, FORK, COLLECT, OUT).
//   - Field offset localparams for the result layout.
//  Sub-module ensemble_majority_vote: combinational.
//   - Inputs: 3 labels, got mask, TIE_PRIO.
//   - Outputs: label, agree.
// TESTING
//  1. 4-beat vector, all ready; results 5,5,5 -> 4 back-to-back forks, then tdata label=5, agree=3, got=7, tlast=1.
//  2. Results 3,7,3 arriving in cycles t, t+4, t+9 -> label=3, agree=2; m_axis_tvalid at t+10.
//  3. Results 1,2,4 with TIE_PRIO=2 -> label=4, agree=1.
//  4. cls_s_tready=3'b101 for 3 cycles, then 3'b111 -> beat held stable; branch 1 sees one valid beat;
//     no duplicate beat to branches 0/2; s_axis_tready low until retire.
//  5. rst asserted in COLLECT after 1 result -> next cycle all outputs 0 and busy=0;
//     a fresh vector votes correctly.
//  6. ENSEMBLE_TIMEOUT_EN, TIMEOUT_CYCLES=16, classifier 2 silent, results 6,6 ->
//     after 16 cycles: label=6, agree=2, got=3'b011, timeout=1.

Source files
------------

// File: rtl/ensemble_pkg.sv
// ensemble_pkg
//   Shared definitions for the three-classifier ensemble scheduler:
//   classifier count, controller state encoding and the bit layout of the
//   voted result word. Result field offsets are given relative to LABEL_W
//   because the label width is a parameter of the modules that import this.
package ensemble_pkg;

  localparam int NUM_CLS = 3;

  // Width of the agreement count (0..3) and of the captured-result mask.
  localparam int AGREE_W = 2;
  localparam int GOT_W   = NUM_CLS;

  // Result word fields above the label, as offsets from bit LABEL_W:
  //   [LABEL_W+AGREE_OFS +: AGREE_W]  agree
  //   [LABEL_W+GOT_OFS   +: GOT_W]    got mask
  //   [LABEL_W+TMO_OFS]               timeout flag
  localparam int AGREE_OFS = 0;
  localparam int GOT_OFS   = AGREE_OFS + AGREE_W;
  localparam int TMO_OFS   = GOT_OFS + GOT_W;
  localparam int META_W    = TMO_OFS + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORK    = 2'd1,
    COLLECT = 2'd2,
    OUT     = 2'd3
  } state_e;

endpackage

// File: rtl/ensemble_majority_vote.sv
// ensemble_majority_vote
//   Combinational vote over up to three captured classifier labels.
//   Only labels whose got bit is set take part.
//   - agree is the size of the largest group of equal captured labels.
//   - The label of the largest group wins.
//   - Among equal-sized groups the lowest index wins, except when all three
//     labels are present and all differ; then TIE_PRIO selects the label.
//   - With nothing captured the result is label=0, agree=0.
// Ports
//   labels  in   NUM_CLS x LABEL_W  captured labels, classifier i at [i]
//   got     in   NUM_CLS            which labels are valid
//   label   out  LABEL_W            voted label
//   agree   out  AGREE_W            number of captured labels equal to it
module ensemble_majority_vote
  import ensemble_pkg::*;
#(
  parameter int LABEL_W  = 8,
  parameter int TIE_PRIO = 0
) (
  input  logic [NUM_CLS-1:0][LABEL_W-1:0] labels,
  input  logic [NUM_CLS-1:0]              got,
  output logic [LABEL_W-1:0]              label,
  output logic [AGREE_W-1:0]              agree
);

  logic [NUM_CLS-1:0][AGREE_W-1:0] match_cnt;
  logic [1:0]                      best_idx;
  logic [AGREE_W-1:0]              best_cnt;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    match_cnt = '0;
    best_idx  = '0;
    best_cnt  = '0;
    label     = '0;
    agree     = '0;

    // Each captured label counts itself plus every other equal captured label.
    for (int i = 0; i < NUM_CLS; i++) begin
      for (int j = 0; j < NUM_CLS; j++) begin
        if (got[i] && got[j] && (labels[i] == labels[j])) begin
          match_cnt[i] = match_cnt[i] + AGREE_W'(1);
        end
      end
    end

    // Strict '>' keeps the lowest index among equal counts.
    for (int i = 0; i < NUM_CLS; i++) begin
      if (match_cnt[i] > best_cnt) begin
        best_cnt = match_cnt[i];
        best_idx = 2'(i);
      end
    end

    // Full three-way disagreement: the priority classifier decides.
    if ((got == '1) && (best_cnt == AGREE_W'(1))) begin
      best_idx = 2'(TIE_PRIO);
    end

    if (best_cnt != '0) begin
      label = labels[best_idx];
    end
    agree = best_cnt;
  end

endmodule

// File: rtl/ensemble_vote_scheduler.sv
// ensemble_vote_scheduler
//   Front/back-end controller for the three-classifier ensemble. A host
//   feature vector is forked beat by beat to all three classifier input
//   streams; one result beat is then collected from each classifier, the
//   labels are majority-voted, and a single result beat goes back to the host.
//
//   Optional feature macro: ENSEMBLE_TIMEOUT_EN
//     defined   - a watchdog limits COLLECT to TIMEOUT_CYCLES cycles, after
//                 which the vote uses only the results captured so far and
//                 the timeout flag is set in the result word.
//     undefined - COLLECT waits indefinitely; the timeout flag is always 0.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_t{data,keep,valid,last} host feature stream in, s_axis_tready out
//   cls_s_t{data,keep,last}        broadcast feature beat to the classifiers
//   cls_s_tvalid / cls_s_tready    per-classifier input handshake
//   cls_r_tdata                    classifier results, i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cls_r_tvalid / cls_r_tready    per-classifier result handshake
//   m_axis_t{data,keep,valid,last} voted result to host, m_axis_tready in
//   busy                           high whenever the controller is not IDLE
//
// Result word: [LABEL_W-1:0] label, then agree (2b), got mask (3b),
// timeout flag (1b); all higher bits 0.
module ensemble_vote_scheduler
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = 4,
  parameter int LABEL_W        = 8,
  parameter int TIE_PRIO       = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,

  output logic [DATA_WIDTH-1:0]         cls_s_tdata,
  output logic [KEEP_WIDTH-1:0]         cls_s_tkeep,
  output logic                          cls_s_tlast,
  output logic [NUM_CLS-1:0]            cls_s_tvalid,
  input  logic [NUM_CLS-1:0]            cls_s_tready,

  input  logic [NUM_CLS*DATA_WIDTH-1:0] cls_r_tdata,
  input  logic [NUM_CLS-1:0]            cls_r_tvalid,
  output logic [NUM_CLS-1:0]            cls_r_tready,

  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,

  output logic                          busy
);

  state_e state, state_next;

  // Fork buffer: the beat currently being offered to the classifiers.
  logic [DATA_WIDTH-1:0] buf_data;
  logic [KEEP_WIDTH-1:0] buf_keep;
  logic                  buf_last;
  logic [NUM_CLS-1:0]    done;      // branches that already took buf_data

  logic [NUM_CLS-1:0]              got;       // results captured so far
  logic [NUM_CLS-1:0][LABEL_W-1:0] label_q;
  logic [NUM_CLS-1:0][LABEL_W-1:0] label_in;
  logic [NUM_CLS-1:0][LABEL_W-1:0] label_next;
  logic [NUM_CLS-1:0]              got_next;

  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] result_d;
  logic [LABEL_W-1:0]    vote_label;
  logic [AGREE_W-1:0]    vote_agree;

  logic [NUM_CLS-1:0] fork_hs;
  logic [NUM_CLS-1:0] res_hs;
  logic               retire;
  logic               s_accept;
  logic               timeout_hit;
  logic               timeout_flag;
  logic               vote_fire;

  // Handshakes are derived straight from state and masks so the output
  // decode below does not feed back into itself.
  assign fork_hs  = (state == FORK)    ? (~done & cls_s_tready) : '0;
  assign res_hs   = (state == COLLECT) ? (~got & cls_r_tvalid)  : '0;
  assign retire   = (state == FORK) && ((done | fork_hs) == '1);
  assign s_accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    for (int i = 0; i < NUM_CLS; i++) begin
      label_in[i]   = cls_r_tdata[i*DATA_WIDTH +: LABEL_W];
      label_next[i] = res_hs[i] ? label_in[i] : label_q[i];
    end
  end

  // Results captured in the voting cycle itself take part in the vote.
  assign got_next = got | res_hs;

`ifdef ENSEMBLE_TIMEOUT_EN
  localparam int TMO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_CNT_W-1:0] tmo_cnt;

  // Counts cycles spent in COLLECT; held at zero elsewhere, so it starts
  // from zero on every entry.
  always_ff @(posedge clk) begin
    if (rst || (state != COLLECT)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
    end
  end

  assign timeout_hit = (state == COLLECT) &&
                       (tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // Only the label field of a result beat matters to the vote.
  logic result_unused;
  assign result_unused = ^cls_r_tdata;

  // A watchdog expiry only counts as a timeout if something is still missing.
  assign timeout_flag = timeout_hit && (got_next != '1);
  assign vote_fire    = (state == COLLECT) && ((got_next == '1) || timeout_hit);

  ensemble_majority_vote #(
    .LABEL_W  (LABEL_W),
    .TIE_PRIO (TIE_PRIO)
  ) u_vote (
    .labels (label_next),
    .got    (got_next),
    .label  (vote_label),
    .agree  (vote_agree)
  );

  always_comb begin
    result_d                                = '0;
    result_d[LABEL_W-1:0]                   = vote_label;
    result_d[LABEL_W+AGREE_OFS +: AGREE_W]  = vote_agree;
    result_d[LABEL_W+GOT_OFS +: GOT_W]      = got_next;
    result_d[LABEL_W+TMO_OFS]               = timeout_flag;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    cls_s_tvalid  = '0;
    cls_r_tready  = '0;

    unique case (state)
      IDLE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_next = FORK;
      end
      FORK: begin
        cls_s_tvalid = ~done;
        // The buffer frees up in the retiring cycle, so the next beat of the
        // same vector can be taken right away. After tlast nothing more is
        // accepted until the vote has been delivered.
        s_axis_tready = retire && !buf_last;
        if (retire) begin
          if (buf_last)           state_next = COLLECT;
          else if (s_axis_tvalid) state_next = FORK;
          else                    state_next = IDLE;
        end
      end
      COLLECT: begin
        cls_r_tready = ~got;
        if (vote_fire) state_next = OUT;
      end
      OUT: begin
        if (m_axis_tready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Nothing is accepted from the host while reset is held.
    if (rst) s_axis_tready = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      buf_data <= '0;
      buf_keep <= '0;
      buf_last <= 1'b0;
      done     <= '0;
      got      <= '0;
      // NOTE: the label store is tiny, so it is reset along with the
      // control state rather than left holding stale labels.
      label_q  <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;

      if (s_accept) begin
        buf_data <= s_axis_tdata;
        buf_keep <= s_axis_tkeep;
        buf_last <= s_axis_tlast;
      end

      if (retire) done <= '0;
      else        done <= done | fork_hs;

      if ((state == OUT) && m_axis_tready) got <= '0;
      else                                  got <= got_next;

      for (int i = 0; i < NUM_CLS; i++) begin
        if (res_hs[i]) label_q[i] <= label_in[i];
      end

      if (vote_fire) result_q <= result_d;
    end
  end

  assign cls_s_tdata = buf_data;
  assign cls_s_tkeep = buf_keep;
  assign cls_s_tlast = buf_last;

  assign m_axis_tvalid = (state == OUT);
  assign m_axis_tdata  = m_axis_tvalid ? result_q : '0;
  assign m_axis_tkeep  = {KEEP_WIDTH{m_axis_tvalid}};
  assign m_axis_tlast  = m_axis_tvalid;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ensemble_vote_scheduler.sv
// tb_ensemble_vote_scheduler
//   Directed bench for ensemble_vote_scheduler. Expected result words are
//   pushed into a scoreboard queue when the stimulus is issued; a monitor
//   pops and compares on every m_axis handshake. A second monitor logs the
//   beats each classifier branch accepts, checked against the sent vector.
//   Build with ENSEMBLE_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_ensemble_vote_scheduler;

  localparam int DW = 32;
  localparam int KW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_axis_tdata;
  logic [KW-1:0]   s_axis_tkeep;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [DW-1:0]   cls_s_tdata;
  logic [KW-1:0]   cls_s_tkeep;
  logic            cls_s_tlast;
  logic [2:0]      cls_s_tvalid;
  logic [2:0]      cls_s_tready;
  logic [3*DW-1:0] cls_r_tdata;
  logic [2:0]      cls_r_tvalid;
  logic [2:0]      cls_r_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            busy;

  ensemble_vote_scheduler #(
    .DATA_WIDTH     (DW),
    .KEEP_WIDTH     (KW),
    .LABEL_W        (8),
    .TIE_PRIO       (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .cls_s_tdata   (cls_s_tdata),
    .cls_s_tkeep   (cls_s_tkeep),
    .cls_s_tlast   (cls_s_tlast),
    .cls_s_tvalid  (cls_s_tvalid),
    .cls_s_tready  (cls_s_tready),
    .cls_r_tdata   (cls_r_tdata),
    .cls_r_tvalid  (cls_r_tvalid),
    .cls_r_tready  (cls_r_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] br0[$];
  logic [DW-1:0] br1[$];
  logic [DW-1:0] br2[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Result word: label[7:0], agree[9:8], got[12:10], timeout[13].
  function automatic logic [DW-1:0] exp_word(input int label, input int agree,
                                             input int got, input int tmo);
    return (32'(label) & 32'hFF) | (32'(agree) << 8) | (32'(got) << 10) | (32'(tmo) << 13);
  endfunction

  // Output scoreboard and per-branch beat logging.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_out", m_axis_tvalid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sb_tdata", m_axis_tdata, e);
        check("sb_tkeep", m_axis_tkeep, 4'hF);
        check("sb_tlast", m_axis_tlast, 1'b1);
      end
    end
    if (!rst) begin
      if (cls_s_tvalid[0] && cls_s_tready[0]) br0.push_back(cls_s_tdata);
      if (cls_s_tvalid[1] && cls_s_tready[1]) br1.push_back(cls_s_tdata);
      if (cls_s_tvalid[2] && cls_s_tready[2]) br2.push_back(cls_s_tdata);
    end
  end

  // Sends n beats base, base+1, ...; returns #1 after the last acceptance edge.
  task automatic send_vector(input int n, input logic [DW-1:0] base, output int stalls);
    bit ok;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      s_axis_tdata  = base + DW'(k);
      s_axis_tkeep  = 4'hF;
      s_axis_tlast  = (k == n - 1);
      s_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (s_axis_tready) begin
          ok = 1'b1;
          break;
        end
        stalls++;
      end
      if (!ok) check("send_hs_timeout", s_axis_tready, 1'b1);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Presents results on the branches in mask; each drops after its handshake.
  task automatic give_res(input logic [2:0] mask, input int l0, input int l1, input int l2);
    logic [2:0] pend, acc;
    cls_r_tdata  = {24'hA5A5A5, 8'(l2), 24'h5A5A5A, 8'(l1), 24'hC3C3C3, 8'(l0)};
    pend         = mask;
    cls_r_tvalid = pend;
    for (int c = 0; c < 100 && pend != 3'b000; c++) begin
      @(negedge clk);
      acc = pend & cls_r_tready;
      @(posedge clk); #1;
      pend         = pend & ~acc;
      cls_r_tvalid = pend;
    end
    if (pend != 3'b000) check("res_hs_timeout", pend, 3'b000);
    cls_r_tvalid = 3'b000;
  endtask

  task automatic wait_out();
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
    check("wait_out_drained", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_branches(input int n, input logic [DW-1:0] base);
    check("br0_count", br0.size(), n);
    check("br1_count", br1.size(), n);
    check("br2_count", br2.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < br0.size()) check("br0_data", br0[k], base + DW'(k));
      if (k < br1.size()) check("br1_data", br1[k], base + DW'(k));
      if (k < br2.size()) check("br2_data", br2[k], base + DW'(k));
    end
    br0.delete();
    br1.delete();
    br2.delete();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {s_axis_tready, cls_s_tdata, cls_s_tkeep, cls_s_tlast, cls_s_tvalid,
                 cls_r_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
                 m_axis_tlast, busy}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int stalls;
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cls_s_tready  = 3'b111;
    cls_r_tdata   = '0;
    cls_r_tvalid  = 3'b000;
    m_axis_tready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: four-beat vector, all branches ready, unanimous 5; output held.
    send_vector(4, 32'h100, stalls);
    check("t1_no_bubble", stalls, 0);
    m_axis_tready = 1'b0;
    sb.push_back(exp_word(5, 3, 7, 0));
    give_res(3'b111, 5, 5, 5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t1_hold_valid", m_axis_tvalid, 1'b1);
      check("t1_hold_data", m_axis_tdata, exp_word(5, 3, 7, 0));
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    wait_out();
    check_branches(4, 32'h100);

    // 2: staggered results 3,7,3 at t, t+4, t+9; output at t+10.
    send_vector(2, 32'h200, stalls);
    sb.push_back(exp_word(3, 2, 7, 0));
    give_res(3'b001, 3, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    give_res(3'b010, 0, 7, 0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t2_not_early", m_axis_tvalid, 1'b0);
    @(posedge clk); #1;
    give_res(3'b100, 0, 0, 3);
    @(negedge clk);
    check("t2_latency", m_axis_tvalid, 1'b1);
    wait_out();
    check_branches(2, 32'h200);

    // 3: three-way disagreement 1,2,4 resolved by TIE_PRIO=2 (simultaneous).
    send_vector(1, 32'h300, stalls);
    sb.push_back(exp_word(4, 1, 7, 0));
    give_res(3'b111, 1, 2, 4);
    wait_out();
    check_branches(1, 32'h300);

    // 3b: a majority beats the priority classifier: 7,3,3 -> 3.
    send_vector(1, 32'h310, stalls);
    sb.push_back(exp_word(3, 2, 7, 0));
    give_res(3'b111, 7, 3, 3);
    wait_out();
    check_branches(1, 32'h310);

    // 4: branch 1 stalls three cycles; beat held, no duplicates, host blocked.
    cls_s_tready  = 3'b101;
    s_axis_tdata  = 32'h400;
    s_axis_tkeep  = 4'hF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("t4_idle_ready", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    s_axis_tdata = 32'h401;
    s_axis_tlast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_host_blocked", s_axis_tready, 1'b0);
      check("t4_beat_stable", cls_s_tdata, 32'h400);
      check("t4_fork_valid", cls_s_tvalid, (c == 0) ? 3'b111 : 3'b010);
      @(posedge clk); #1;
    end
    cls_s_tready = 3'b111;
    @(negedge clk);
    check("t4_retire_ready", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    sb.push_back(exp_word(8, 3, 7, 0));
    give_res(3'b111, 8, 8, 8);
    wait_out();
    check_branches(2, 32'h400);

    // 5: reset during COLLECT after one result, then a fresh vector.
    send_vector(2, 32'h500, stalls);
    give_res(3'b001, 1, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("t5_reset_outputs");
    check("t5_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    br0.delete();
    br1.delete();
    br2.delete();
    send_vector(1, 32'h520, stalls);
    sb.push_back(exp_word(9, 2, 7, 0));
    give_res(3'b111, 9, 9, 2);
    wait_out();
    check_branches(1, 32'h520);

    // 6: classifier 2 silent.
    send_vector(1, 32'h600, stalls);
`ifdef ENSEMBLE_TIMEOUT_EN
    sb.push_back(exp_word(6, 2, 3, 1));
    give_res(3'b011, 6, 6, 0);
    wait_out();
`else
    give_res(3'b011, 6, 6, 0);
    repeat (40) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t6_still_waiting", m_axis_tvalid, 1'b0);
    check("t6_busy", busy, 1'b1);
    @(posedge clk); #1;
    sb.push_back(exp_word(6, 3, 7, 0));
    give_res(3'b100, 0, 0, 6);
    wait_out();
`endif
    check_branches(1, 32'h600);

    @(negedge clk);
    check("final_idle", busy, 1'b0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
